// File: rtl/operation_encoder_mp_if.sv
// Bus bundle for operation_encoder_mp.
//   key_down[511:0]  : level per scan code from the keyboard decoder
//   state[2:0]       : top-level game state
//   h_code, v_code   : per-player 2-bit steering / throttle codes
//   boost            : per-player boost active
//   boost_ready      : per-player boost FSM idle (can be triggered)
//   honk, honk_pulse : per-player honk level / one-cycle press pulse
//   dbg_boost_state  : per-player boost FSM state (2 bits each) for checkers
// Handshake: none. Every signal is a level; inputs are sampled on every
// rising clock edge, and outputs are registered with one cycle of latency.
interface operation_encoder_mp_if #(
  parameter int NUM_PLAYERS = 2
);
  logic [511:0]               key_down;
  logic [2:0]                 state;
  logic [2*NUM_PLAYERS-1:0]   h_code;
  logic [2*NUM_PLAYERS-1:0]   v_code;
  logic [NUM_PLAYERS-1:0]     boost;
  logic [NUM_PLAYERS-1:0]     boost_ready;
  logic [NUM_PLAYERS-1:0]     honk;
  logic [NUM_PLAYERS-1:0]     honk_pulse;
  logic [2*NUM_PLAYERS-1:0]   dbg_boost_state;

  modport master (
    output key_down, state,
    input  h_code, v_code, boost, boost_ready, honk, honk_pulse, dbg_boost_state
  );

  modport slave (
    input  key_down, state,
    output h_code, v_code, boost, boost_ready, honk, honk_pulse, dbg_boost_state
  );
endinterface

// File: rtl/operation_encoder_mp.sv
// operation_encoder_mp: maps the keyboard key-state vector to per-player
// steering, throttle, boost and honk codes for NUM_PLAYERS carts.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : operation_encoder_mp_if.slave (key_down/state in, codes out)
// Optional build macro OPERATION_HONK_ANYSTATE_EN: when defined, honk and
// honk_pulse work in every game state; otherwise they are gated by racing.
// KEY_MAP: player p uses bits [54p+53:54p], fields (LSB first, 9 bits each)
// up, down, left, right, boost, honk. The default covers two players.
module operation_encoder_mp #(
  parameter int                      NUM_PLAYERS   = 2,
  parameter logic [54*NUM_PLAYERS-1:0] KEY_MAP     = {
    9'h070, 9'h059, 9'h04B, 9'h03B, 9'h042, 9'h043,
    9'h029, 9'h012, 9'h023, 9'h01C, 9'h01B, 9'h01D},
  parameter bit                      SOCD_LAST_WIN = 1'b0,
  parameter int                      BOOST_LEN     = 100000000,
  parameter int                      COOLDOWN_LEN  = 50000000,
  parameter logic [2:0]              RACING_STATE  = 3'd4
) (
  input logic                   clk,
  input logic                   rst,
  operation_encoder_mp_if.slave bus
);
  localparam int MAX_LEN = (BOOST_LEN > COOLDOWN_LEN) ? BOOST_LEN : COOLDOWN_LEN;
  localparam int CW      = $clog2(MAX_LEN + 1);
  localparam int NK      = 6 * NUM_PLAYERS;
  localparam int F_UP = 0, F_DN = 1, F_LT = 2, F_RT = 3, F_BS = 4, F_HK = 5;

  typedef enum logic [1:0] {B_IDLE = 2'd0, B_ACTIVE = 2'd1, B_COOL = 2'd2} bst_e;

  logic                   racing;
  logic [NK-1:0]          key_lv, press;
  logic [NK-1:0]          prev_q, prev_d;
  bst_e                   bst_q [NUM_PLAYERS];
  bst_e                   bst_d [NUM_PLAYERS];
  logic [CW-1:0]          cnt_q [NUM_PLAYERS];
  logic [CW-1:0]          cnt_d [NUM_PLAYERS];
  logic [1:0]             hmem_q [NUM_PLAYERS];
  logic [1:0]             hmem_d [NUM_PLAYERS];
  logic [1:0]             vmem_q [NUM_PLAYERS];
  logic [1:0]             vmem_d [NUM_PLAYERS];
  logic [2*NUM_PLAYERS-1:0] h_code_q, h_code_d, v_code_q, v_code_d;
  logic [NUM_PLAYERS-1:0] boost_q, boost_d, ready_q, ready_d;
  logic [NUM_PLAYERS-1:0] honk_q, honk_d, pulse_q, pulse_d;

  // Axis memory uses the output code itself: 0 NONE, 1 first key, 2 second key.
  function automatic logic [1:0] next_mem(input logic a, input logic b,
                                          input logic pa, input logic pb,
                                          input logic [1:0] mem);
    if (!a && !b)       return 2'd0;
    else if (pa && !pb) return 2'd1;
    else if (pb && !pa) return 2'd2;
    else                return mem;
  endfunction

  function automatic logic [1:0] resolve(input logic a, input logic b,
                                         input logic [1:0] mem);
    if (a && !b)                      return 2'd1;
    else if (b && !a)                 return 2'd2;
    else if (a && b && SOCD_LAST_WIN) return mem;
    else                              return 2'd0;
  endfunction

  // Gather the mapped key levels; players sharing a code each get a copy.
  always_comb begin
    key_lv = '0;
    for (int p = 0; p < NUM_PLAYERS; p++)
      for (int f = 0; f < 6; f++)
        key_lv[6*p+f] = bus.key_down[KEY_MAP[54*p + 9*f +: 9]];
  end

  always_comb begin
    racing   = (bus.state == RACING_STATE);
    press    = key_lv & ~prev_q;
    prev_d   = key_lv;   // tracks keys even outside racing
    h_code_d = '0;
    v_code_d = '0;
    boost_d  = '0;
    ready_d  = '0;
    honk_d   = '0;
    pulse_d  = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      bst_d[p]  = B_IDLE;
      cnt_d[p]  = '0;
      hmem_d[p] = 2'd0;
      vmem_d[p] = 2'd0;
      if (racing) begin
        hmem_d[p] = next_mem(key_lv[6*p+F_LT], key_lv[6*p+F_RT],
                             press[6*p+F_LT], press[6*p+F_RT], hmem_q[p]);
        vmem_d[p] = next_mem(key_lv[6*p+F_UP], key_lv[6*p+F_DN],
                             press[6*p+F_UP], press[6*p+F_DN], vmem_q[p]);
        // The updated memory is used so a fresh press wins on the same edge.
        h_code_d[2*p +: 2] = resolve(key_lv[6*p+F_LT], key_lv[6*p+F_RT], hmem_d[p]);
        v_code_d[2*p +: 2] = resolve(key_lv[6*p+F_UP], key_lv[6*p+F_DN], vmem_d[p]);

        bst_d[p] = bst_q[p];
        cnt_d[p] = cnt_q[p];
        case (bst_q[p])
          B_IDLE: begin
            if (press[6*p+F_BS]) begin
              bst_d[p] = B_ACTIVE;
              cnt_d[p] = '0;
            end
          end
          B_ACTIVE: begin
            // Release and expiry together still make a single move to cooldown.
            if (!key_lv[6*p+F_BS] || (cnt_q[p] == CW'(BOOST_LEN - 1))) begin
              bst_d[p] = B_COOL;
              cnt_d[p] = '0;
            end else begin
              cnt_d[p] = cnt_q[p] + CW'(1);
            end
          end
          B_COOL: begin
            if (cnt_q[p] == CW'(COOLDOWN_LEN - 1)) begin
              bst_d[p] = B_IDLE;
              cnt_d[p] = '0;
            end else begin
              cnt_d[p] = cnt_q[p] + CW'(1);
            end
          end
          default: begin
            bst_d[p] = B_IDLE;
            cnt_d[p] = '0;
          end
        endcase
      end
      boost_d[p] = (bst_d[p] == B_ACTIVE);
      ready_d[p] = (bst_d[p] == B_IDLE);
`ifdef OPERATION_HONK_ANYSTATE_EN
      honk_d[p]  = key_lv[6*p+F_HK];
      pulse_d[p] = press[6*p+F_HK];
`else
      honk_d[p]  = racing & key_lv[6*p+F_HK];
      pulse_d[p] = racing & press[6*p+F_HK];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q   <= '0;
      h_code_q <= '0;
      v_code_q <= '0;
      boost_q  <= '0;
      ready_q  <= '1;
      honk_q   <= '0;
      pulse_q  <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        bst_q[p]  <= B_IDLE;
        cnt_q[p]  <= '0;
        hmem_q[p] <= 2'd0;
        vmem_q[p] <= 2'd0;
      end
    end else begin
      prev_q   <= prev_d;
      h_code_q <= h_code_d;
      v_code_q <= v_code_d;
      boost_q  <= boost_d;
      ready_q  <= ready_d;
      honk_q   <= honk_d;
      pulse_q  <= pulse_d;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        bst_q[p]  <= bst_d[p];
        cnt_q[p]  <= cnt_d[p];
        hmem_q[p] <= hmem_d[p];
        vmem_q[p] <= vmem_d[p];
      end
    end
  end

  always_comb begin
    bus.dbg_boost_state = '0;
    for (int p = 0; p < NUM_PLAYERS; p++)
      bus.dbg_boost_state[2*p +: 2] = bst_q[p];
  end

  assign bus.h_code      = h_code_q;
  assign bus.v_code      = v_code_q;
  assign bus.boost       = boost_q;
  assign bus.boost_ready = ready_q;
  assign bus.honk        = honk_q;
  assign bus.honk_pulse  = pulse_q;
endmodule

// File: tb/tb_operation_encoder_mp.sv
module tb_operation_encoder_mp;
  localparam int NP = 2;
  localparam int BL = 4;
  localparam int CL = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [511:0] key_down;
  logic [2:0]   state;

  operation_encoder_mp_if #(.NUM_PLAYERS(NP)) bus_a ();
  operation_encoder_mp_if #(.NUM_PLAYERS(NP)) bus_b ();
  assign bus_a.key_down = key_down;
  assign bus_a.state    = state;
  assign bus_b.key_down = key_down;
  assign bus_b.state    = state;

  operation_encoder_mp #(.NUM_PLAYERS(NP), .SOCD_LAST_WIN(1'b0),
                         .BOOST_LEN(BL), .COOLDOWN_LEN(CL)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a));
  operation_encoder_mp #(.NUM_PLAYERS(NP), .SOCD_LAST_WIN(1'b1),
                         .BOOST_LEN(BL), .COOLDOWN_LEN(CL)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b));

  // ---------------- reference model ----------------
  // Scan codes per player: up, down, left, right, boost, honk.
  int key_tab [NP][6] = '{'{'h1D, 'h1B, 'h1C, 'h23, 'h12, 'h29},
                          '{'h43, 'h42, 'h3B, 'h4B, 'h59, 'h70}};
  bit       prev_m [NP][6];
  bit       act_m  [NP];
  bit       cool_m [NP];
  int       rem_m  [NP];        // cycles left to show in the current boost phase
  bit [1:0] last_m [2][NP][2];  // [socd mode][player][axis] last pressed direction

  logic [2*NP-1:0] exp_h [2];
  logic [2*NP-1:0] exp_v [2];
  logic [NP-1:0]   exp_boost, exp_ready, exp_honk, exp_pulse;

  int n_vec = 0;
  int n_err = 0;

  // Direction from two opposing keys a (code 1) and b (code 2).
  function automatic bit [1:0] axis_out(input bit a, input bit b, input bit last_win,
                                        input bit [1:0] last);
    if (a && b) return last_win ? last : 2'd0;
    if (a) return 2'd1;
    if (b) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_step();
    bit k [6];
    bit pr [6];
    bit racing, hk_en;
    racing = (state == 3'd4);
`ifdef OPERATION_HONK_ANYSTATE_EN
    hk_en = 1'b1;
`else
    hk_en = racing;
`endif
    for (int m = 0; m < 2; m++) begin
      exp_h[m] = '0;
      exp_v[m] = '0;
    end
    exp_boost = '0; exp_ready = '1; exp_honk = '0; exp_pulse = '0;
    for (int p = 0; p < NP; p++) begin
      for (int f = 0; f < 6; f++) begin
        k[f]  = key_down[key_tab[p][f]];
        pr[f] = k[f] && !prev_m[p][f];
        prev_m[p][f] = rst ? 1'b0 : k[f];
      end
      if (rst || !racing) begin
        act_m[p] = 0; cool_m[p] = 0; rem_m[p] = 0;
        for (int m = 0; m < 2; m++) begin
          last_m[m][p][0] = 0;
          last_m[m][p][1] = 0;
        end
      end else begin
        for (int m = 0; m < 2; m++) begin
          // axis 0: steering (left, right); axis 1: throttle (up, down)
          for (int ax = 0; ax < 2; ax++) begin
            bit a, b, pa, pb;
            a  = (ax == 0) ? k[2]  : k[0];
            b  = (ax == 0) ? k[3]  : k[1];
            pa = (ax == 0) ? pr[2] : pr[0];
            pb = (ax == 0) ? pr[3] : pr[1];
            if (pa && !pb) last_m[m][p][ax] = 2'd1;
            if (pb && !pa) last_m[m][p][ax] = 2'd2;
            if (!a && !b)  last_m[m][p][ax] = 2'd0;
            if (ax == 0) exp_h[m][2*p +: 2] = axis_out(a, b, m == 1, last_m[m][p][ax]);
            else         exp_v[m][2*p +: 2] = axis_out(a, b, m == 1, last_m[m][p][ax]);
          end
        end
        if (act_m[p]) begin
          rem_m[p]--;
          if (!k[4] || rem_m[p] == 0) begin
            act_m[p] = 0; cool_m[p] = 1; rem_m[p] = CL;
          end
        end else if (cool_m[p]) begin
          rem_m[p]--;
          if (rem_m[p] == 0) cool_m[p] = 0;
        end else if (pr[4]) begin
          act_m[p] = 1; rem_m[p] = BL;
        end
      end
      exp_boost[p] = act_m[p];
      exp_ready[p] = !act_m[p] && !cool_m[p];
      if (!rst) begin
        exp_honk[p]  = hk_en && k[5];
        exp_pulse[p] = hk_en && pr[5];
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("h_code_socd0", 8'(bus_a.h_code), 8'(exp_h[0]));
    check("v_code_socd0", 8'(bus_a.v_code), 8'(exp_v[0]));
    check("h_code_socd1", 8'(bus_b.h_code), 8'(exp_h[1]));
    check("v_code_socd1", 8'(bus_b.v_code), 8'(exp_v[1]));
    check("boost_a",      8'(bus_a.boost),       8'(exp_boost));
    check("ready_a",      8'(bus_a.boost_ready), 8'(exp_ready));
    check("honk_a",       8'(bus_a.honk),        8'(exp_honk));
    check("pulse_a",      8'(bus_a.honk_pulse),  8'(exp_pulse));
    check("boost_b",      8'(bus_b.boost),       8'(exp_boost));
    check("ready_b",      8'(bus_b.boost_ready), 8'(exp_ready));
    check("honk_b",       8'(bus_b.honk),        8'(exp_honk));
    check("pulse_b",      8'(bus_b.honk_pulse),  8'(exp_pulse));
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int cnt_a, cnt_b, cnt_c;

  initial begin
    rst = 1'b1; key_down = '0; state = 3'd0;
    ticks(2);
    rst = 1'b0;

    // Throttle: single key, release, then outside racing.
    state = 3'd4;
    key_down['h1D] = 1'b1; ticks(3);
    key_down['h1D] = 1'b0; ticks(2);
    state = 3'd2; key_down['h1D] = 1'b1; ticks(2);
    key_down['h1D] = 1'b0; state = 3'd4; tick();

    // Steering with both keys held, both resolution modes.
    key_down['h1C] = 1'b1; ticks(2);
    key_down['h23] = 1'b1; ticks(2);
    key_down['h23] = 1'b0; ticks(2);
    key_down['h1C] = 1'b0; ticks(2);

    // Boost held through expiry and cooldown, then re-press.
    cnt_a = 0; cnt_b = 0;
    key_down['h12] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus_a.boost[0]) cnt_a++;
      if (!bus_a.boost_ready[0]) cnt_b++;
    end
    check("boost_hold_cycles", 8'(cnt_a), 8'd4);
    check("not_ready_cycles",  8'(cnt_b), 8'd7);
    key_down['h12] = 1'b0; tick();
    // Re-press, tap for two cycles.
    key_down['h12] = 1'b1; tick();
    check("boost_retrigger", 8'(bus_a.boost[0]), 8'd1);
    tick();
    key_down['h12] = 1'b0; ticks(5);

    // Honk in racing, then held across entry into racing.
    cnt_a = 0; cnt_b = 0;
    key_down['h70] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus_a.honk[1]) cnt_a++;
      if (bus_a.honk_pulse[1]) cnt_b++;
    end
    check("honk_cycles",  8'(cnt_a), 8'd5);
    check("pulse_cycles", 8'(cnt_b), 8'd1);
    key_down['h70] = 1'b0; tick();
    state = 3'd2; key_down['h70] = 1'b1; ticks(2);
    state = 3'd4;
    cnt_c = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus_a.honk_pulse[1]) cnt_c++;
    end
    check("no_pulse_on_entry", 8'(cnt_c), 8'd0);
    key_down['h70] = 1'b0; ticks(2);

    // Reset in the middle of an active boost.
    key_down['h12] = 1'b1; key_down['h1C] = 1'b1; ticks(3);
    rst = 1'b1; tick();
    check("rst_boost", 8'(bus_a.boost), 8'd0);
    check("rst_ready", 8'(bus_a.boost_ready), 8'd3);
    rst = 1'b0; ticks(2);
    key_down = '0; ticks(4);

    // Random key activity over both players' maps plus an unmapped key.
    for (int i = 0; i < 2000; i++) begin
      for (int p = 0; p < NP; p++)
        for (int f = 0; f < 6; f++)
          if ($urandom_range(0, 3) == 0)
            key_down[key_tab[p][f]] = ~key_down[key_tab[p][f]];
      if ($urandom_range(0, 3) == 0) key_down['h55] = ~key_down['h55];
      state = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : 3'd4;
      rst   = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
